// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants and helpers for the LFSR stream and its step function
package lfsr_pkg;

    localparam logic [127:0] TAPS_128 = 128'h8000_0000_0000_0000_0000_0000_1400_0002;
    localparam logic [15:0]  TAPS_16  = 16'hB400;
    localparam logic [127:0] SEED_128 = 128'hACE1_BABE_CAFE_DEAD_BEEF_FEED_FACE_C0DE;

    function automatic int fill_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: combinational Fibonacci LFSR advance by STEP bits
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 128,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_128,
    parameter int               STEP  = 1
) (
    input  logic [WIDTH-1:0] state_in,
    output logic [WIDTH-1:0] state_out
);

    always_comb begin
        state_out = state_in;
        for (int i = 0; i < STEP; i++)
            state_out = {state_out[WIDTH-2:0], ^(state_out & TAPS)};
    end

endmodule

// File: rtl/lfsr_stream.sv
// lfsr_stream: LFSR packing fresh bits into back-pressured words with reseed
module lfsr_stream
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 128,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_128,
    parameter logic [WIDTH-1:0] SEED  = SEED_128,
    parameter int               STEP  = 1,
    parameter int               OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             seed_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [31:0]      word_count
);

    localparam int            NFILL = OUT_W / STEP;
    localparam int            FW    = fill_w(NFILL);
    localparam logic [FW-1:0] LAST  = FW'(NFILL - 1);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] nxt;
    logic [FW-1:0]    fill;
    logic             adv;
    logic             hs;
    logic             zero_seed;

    assign hs        = out_valid && out_ready;
    assign adv       = en && (!out_valid || out_ready) && !seed_load;
    assign zero_seed = seed_in == '0;

    lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS), .STEP(STEP)) u_step (
        .state_in (state),
        .state_out(nxt)
    );

    // A zero seed would lock the register at zero, so SEED stands in and the swap is flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEED;
            fill       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            seed_err   <= 1'b0;
            word_count <= '0;
        end else begin
            seed_err <= 1'b0;
            if (hs)
                word_count <= word_count + 32'd1;
            if (seed_load) begin
                state     <= zero_seed ? SEED : seed_in;
                seed_err  <= zero_seed;
                fill      <= '0;
                out_valid <= 1'b0;
            end else if (adv) begin
                state <= nxt;
                if (fill == LAST) begin
                    fill      <= '0;
                    out_data  <= nxt[OUT_W-1:0];
                    out_valid <= 1'b1;
                end else begin
                    fill <= fill + 1'b1;
                    if (hs)
                        out_valid <= 1'b0;
                end
            end else if (hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_stream.sv
// tb_lfsr_stream: directed checks of the LFSR word stream with hand-computed vectors
module tb_lfsr_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en1 = 1'b0, sl1 = 1'b0, rdy1 = 1'b0;
    logic [15:0] si1 = '0;
    logic        se1, ov1;
    logic [3:0]  od1;
    logic [31:0] wc1;
    logic        en4 = 1'b0, sl4 = 1'b0, rdy4 = 1'b0;
    logic [15:0] si4 = '0;
    logic        se4, ov4;
    logic [3:0]  od4;
    logic [31:0] wc4;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lfsr_stream #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'hACE1), .STEP(1), .OUT_W(4)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .seed_load(sl1), .seed_in(si1), .seed_err(se1),
        .out_valid(ov1), .out_ready(rdy1), .out_data(od1), .word_count(wc1)
    );

    lfsr_stream #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'hACE1), .STEP(4), .OUT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .seed_load(sl4), .seed_in(si4), .seed_err(se4),
        .out_valid(ov4), .out_ready(rdy4), .out_data(od4), .word_count(wc4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en1 = 1'b0; rdy1 = 1'b0; sl1 = 1'b0;
        rst = 1'b1;
        tick(); tick();
        checks++; if (dut1.state !== 16'hACE1) begin failures++; $display("FAIL reset_state got %h exp ace1", dut1.state); end
        checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", ov1); end
        checks++; if (od1 !== 4'h0) begin failures++; $display("FAIL reset_data got %h exp 0", od1); end
        checks++; if (wc1 !== 32'd0) begin failures++; $display("FAIL reset_count got %0d exp 0", wc1); end
        checks++; if (se1 !== 1'b0) begin failures++; $display("FAIL reset_seed_err got %b exp 0", se1); end
        rst = 1'b0;
        tick(); tick();
        checks++; if (dut1.state !== 16'hACE1) begin failures++; $display("FAIL en_low_hold got %h exp ace1", dut1.state); end
    endtask

    task automatic test_stream();
        logic [15:0] exp_s [4] = '{16'h59C3, 16'hB387, 16'h670F, 16'hCE1E};
        do_reset();
        en1 = 1'b1; rdy1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (dut1.state !== exp_s[i]) begin failures++; $display("FAIL stream_state%0d got %h exp %h", i, dut1.state, exp_s[i]); end
            checks++; if (ov1 !== (i == 3)) begin failures++; $display("FAIL stream_valid%0d got %b exp %b", i, ov1, i == 3); end
        end
        checks++; if (od1 !== 4'hE) begin failures++; $display("FAIL stream_data got %h exp e", od1); end
        checks++; if (wc1 !== 32'd0) begin failures++; $display("FAIL stream_count0 got %0d exp 0", wc1); end
        tick();
        checks++; if (wc1 !== 32'd1) begin failures++; $display("FAIL stream_count1 got %0d exp 1", wc1); end
        checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL stream_valid_drop got %b exp 0", ov1); end
        checks++; if (dut1.state !== 16'h9C3C) begin failures++; $display("FAIL stream_state5 got %h exp 9c3c", dut1.state); end
        en1 = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        en1 = 1'b1; rdy1 = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (od1 !== 4'hE || ov1 !== 1'b1 || dut1.state !== 16'hCE1E || wc1 !== 32'd0) begin
                failures++; $display("FAIL bp_hold%0d got v=%b d=%h s=%h c=%0d exp v=1 d=e s=ce1e c=0", i, ov1, od1, dut1.state, wc1);
            end
        end
        rdy1 = 1'b1;
        tick();
        checks++; if (wc1 !== 32'd1) begin failures++; $display("FAIL bp_release_count got %0d exp 1", wc1); end
        checks++; if (dut1.state !== 16'h9C3C) begin failures++; $display("FAIL bp_release_state got %h exp 9c3c", dut1.state); end
        repeat (3) tick();
        checks++; if (ov1 !== 1'b1 || od1 !== 4'h4) begin failures++; $display("FAIL bp_word2 got v=%b d=%h exp v=1 d=4", ov1, od1); end
        rdy1 = 1'b0;
        tick(); tick();
        checks++; if (wc1 !== 32'd1) begin failures++; $display("FAIL bp_single_hs got %0d exp 1", wc1); end
        en1 = 1'b0;
    endtask

    task automatic test_step4();
        logic [15:0] exp_s [3] = '{16'hCE1E, 16'hE1E4, 16'h1E45};
        do_reset();
        en4 = 1'b1; rdy4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ov4 !== 1'b1 || od4 !== exp_s[i][3:0] || wc4 !== 32'(i)) begin
                failures++; $display("FAIL step4_word%0d got v=%b d=%h c=%0d exp v=1 d=%h c=%0d", i, ov4, od4, wc4, exp_s[i][3:0], i);
            end
            checks++; if (dut4.state !== exp_s[i]) begin failures++; $display("FAIL step4_state%0d got %h exp %h", i, dut4.state, exp_s[i]); end
        end
        en4 = 1'b0; rdy4 = 1'b0;
    endtask

    task automatic test_back_to_back_zero_seed();
        do_reset();
        en1 = 1'b1; rdy1 = 1'b0;
        repeat (4) tick();
        sl1 = 1'b1; si1 = 16'h0000;
        tick();
        checks++; if (se1 !== 1'b1) begin failures++; $display("FAIL zseed_err got %b exp 1", se1); end
        checks++; if (dut1.state !== 16'hACE1) begin failures++; $display("FAIL zseed_state got %h exp ace1", dut1.state); end
        checks++; if (ov1 !== 1'b0 || wc1 !== 32'd0) begin failures++; $display("FAIL zseed_discard got v=%b c=%0d exp v=0 c=0", ov1, wc1); end
        sl1 = 1'b0; rdy1 = 1'b1;
        tick();
        checks++; if (se1 !== 1'b0) begin failures++; $display("FAIL zseed_err_pulse got %b exp 0", se1); end
        checks++; if (dut1.state !== 16'h59C3) begin failures++; $display("FAIL zseed_replay1 got %h exp 59c3", dut1.state); end
        repeat (3) tick();
        checks++; if (ov1 !== 1'b1 || od1 !== 4'hE || dut1.state !== 16'hCE1E) begin
            failures++; $display("FAIL zseed_replay_word got v=%b d=%h s=%h exp v=1 d=e s=ce1e", ov1, od1, dut1.state);
        end
        tick();
        checks++; if (wc1 !== 32'd1) begin failures++; $display("FAIL zseed_replay_count got %0d exp 1", wc1); end
        en1 = 1'b0;
    endtask

    task automatic test_seed_one();
        do_reset();
        en1 = 1'b1; rdy1 = 1'b0;
        repeat (4) tick();
        sl1 = 1'b1; si1 = 16'h0001; rdy1 = 1'b1;
        tick();
        checks++; if (dut1.state !== 16'h0001 || se1 !== 1'b0) begin failures++; $display("FAIL seed1_load got s=%h e=%b exp s=0001 e=0", dut1.state, se1); end
        checks++; if (wc1 !== 32'd1 || ov1 !== 1'b0) begin failures++; $display("FAIL seed1_hs got c=%0d v=%b exp c=1 v=0", wc1, ov1); end
        sl1 = 1'b0;
        tick();
        checks++; if (dut1.state !== 16'h0002 || se1 !== 1'b0) begin failures++; $display("FAIL seed1_adv got s=%h e=%b exp s=0002 e=0", dut1.state, se1); end
        en1 = 1'b0;
    endtask

    task automatic test_rst_mid();
        do_reset();
        en1 = 1'b1; rdy1 = 1'b1;
        repeat (6) tick();
        checks++; if (dut1.fill !== 2'd2 || wc1 !== 32'd1) begin failures++; $display("FAIL mid_setup got f=%0d c=%0d exp f=2 c=1", dut1.fill, wc1); end
        rst = 1'b1; sl1 = 1'b1; si1 = 16'h1234;
        tick();
        checks++; if (dut1.state !== 16'hACE1 || dut1.fill !== 2'd0) begin failures++; $display("FAIL mid_rst_state got s=%h f=%0d exp s=ace1 f=0", dut1.state, dut1.fill); end
        checks++; if (ov1 !== 1'b0 || wc1 !== 32'd0 || se1 !== 1'b0) begin failures++; $display("FAIL mid_rst_out got v=%b c=%0d e=%b exp v=0 c=0 e=0", ov1, wc1, se1); end
        rst = 1'b0; sl1 = 1'b0; en1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_step4();
        test_back_to_back_zero_seed();
        test_seed_one();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
